// File: rtl/idli_io_unit_m.sv
// Nibble-serial I/O unit: external din/dout valid/accept ports on one side,
// word-serial IN/OUT transfers locked to the core nibble counter on the other.
module idli_io_unit_m #(
   parameter int WORD_W    = 16,
   parameter int NIB_W     = 4,
   parameter int NIBS      = WORD_W / NIB_W,
   parameter int CTR_W     = $clog2(NIBS),
   parameter int IN_DEPTH  = 4,
   parameter int OUT_DEPTH = 4
) (
   input  logic             i_core_gck,
   input  logic             i_core_rst_n,
   input  logic [CTR_W-1:0] i_io_ctr,
   input  logic             i_io_ctr_last_cycle,
   input  logic             i_io_rd_req,
   output logic [NIB_W-1:0] o_io_rd_data,
   output logic             o_io_rd_vld,
   input  logic             i_io_wr_req,
   input  logic [NIB_W-1:0] i_io_wr_data,
   output logic             o_io_stall,
   input  logic [NIB_W-1:0] i_core_din,
   input  logic             i_core_din_vld,
   output logic             o_core_din_acp,
   output logic [NIB_W-1:0] o_core_dout,
   output logic             o_core_dout_vld,
   input  logic             i_core_dout_acp
);

   localparam int IN_AW  = $clog2(IN_DEPTH);
   localparam int OUT_AW = $clog2(OUT_DEPTH);
   localparam logic [IN_AW:0]  IN_ONE  = (IN_AW+1)'(1);
   localparam logic [OUT_AW:0] OUT_ONE = (OUT_AW+1)'(1);
   localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);
   localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(NIBS - 1);

   // Low until the first edge after reset release, so every output stays 0
   // through reset and release takes effect synchronously.
   logic run_reg;

   logic [WORD_W-1:0] in_mem [IN_DEPTH];
   logic [IN_AW:0]    in_wp_reg, in_rp_reg;
   logic              in_empty, in_full, in_push, in_pop;
   logic [WORD_W-1:0] in_head, in_word;
   logic [NIB_W-1:0]  in_head_nib [NIBS];
   logic [NIB_W-1:0]  asm_reg [NIBS];
   logic [CTR_W-1:0]  in_idx_reg;
   logic              din_acp, din_xfer;

   logic [WORD_W-1:0] out_mem [OUT_DEPTH];
   logic [OUT_AW:0]   out_wp_reg, out_rp_reg;
   logic              out_empty, out_full, out_push, out_pop;
   logic [WORD_W-1:0] out_head, out_word;
   logic [NIB_W-1:0]  out_head_nib [NIBS];
   logic [NIB_W-1:0]  wbuf_reg [NIBS];
   logic [CTR_W-1:0]  out_idx_reg;
   logic              dout_vld, dout_xfer;

   logic ctr_first;
   logic rd_active, rd_stall, wr_active, wr_stall;
   logic rd_active_reg, rd_stall_reg, wr_active_reg, wr_stall_reg;

   always_ff @(posedge i_core_gck or negedge i_core_rst_n) begin
      if (!i_core_rst_n) run_reg <= 1'b0;
      else               run_reg <= 1'b1;
   end

   // ---------------- input FIFO and assembler ----------------
   assign in_empty = (in_wp_reg == in_rp_reg);
   assign in_full  = (in_wp_reg[IN_AW] != in_rp_reg[IN_AW]) &&
                     (in_wp_reg[IN_AW-1:0] == in_rp_reg[IN_AW-1:0]);
   assign in_head  = in_mem[in_rp_reg[IN_AW-1:0]];

   assign din_acp  = run_reg & ~in_full;
   assign din_xfer = i_core_din_vld & din_acp;
   assign in_push  = din_xfer & (in_idx_reg == CTR_LAST);
   assign in_pop   = rd_active & i_io_ctr_last_cycle;

   // The final nibble bypasses the assembler so the word is pushed on the
   // same edge that transfers it.
   for (genvar gi = 0; gi < NIBS; gi++) begin : g_in_nib
      assign in_word[gi*NIB_W +: NIB_W] =
         (in_idx_reg == CTR_W'(gi)) ? i_core_din : asm_reg[gi];
      assign in_head_nib[gi] = in_head[gi*NIB_W +: NIB_W];
   end

   always_ff @(posedge i_core_gck) begin
      if (din_xfer) asm_reg[in_idx_reg] <= i_core_din;
      if (in_push)  in_mem[in_wp_reg[IN_AW-1:0]] <= in_word;
   end

   always_ff @(posedge i_core_gck or negedge i_core_rst_n) begin
      if (!i_core_rst_n) begin
         in_idx_reg <= '0;
         in_wp_reg  <= '0;
         in_rp_reg  <= '0;
      end else begin
         if (din_xfer) in_idx_reg <= in_idx_reg + CTR_ONE;
         if (in_push)  in_wp_reg  <= in_wp_reg + IN_ONE;
         if (in_pop)   in_rp_reg  <= in_rp_reg + IN_ONE;
      end
   end

   // ---------------- word-time grant / stall ----------------
   always_comb begin
      ctr_first = (i_io_ctr == '0);
      rd_active = rd_active_reg;
      rd_stall  = rd_stall_reg;
      wr_active = wr_active_reg;
      wr_stall  = wr_stall_reg;
      if (ctr_first) begin
         rd_active = run_reg & i_io_rd_req & ~in_empty;
         rd_stall  = run_reg & i_io_rd_req &  in_empty;
         wr_active = run_reg & i_io_wr_req & ~out_full;
         wr_stall  = run_reg & i_io_wr_req &  out_full;
      end
   end

   always_ff @(posedge i_core_gck or negedge i_core_rst_n) begin
      if (!i_core_rst_n) begin
         rd_active_reg <= 1'b0;
         rd_stall_reg  <= 1'b0;
         wr_active_reg <= 1'b0;
         wr_stall_reg  <= 1'b0;
      end else begin
         rd_active_reg <= rd_active & ~i_io_ctr_last_cycle;
         rd_stall_reg  <= rd_stall  & ~i_io_ctr_last_cycle;
         wr_active_reg <= wr_active & ~i_io_ctr_last_cycle;
         wr_stall_reg  <= wr_stall  & ~i_io_ctr_last_cycle;
      end
   end

   // ---------------- output FIFO and serialiser ----------------
   assign out_empty = (out_wp_reg == out_rp_reg);
   assign out_full  = (out_wp_reg[OUT_AW] != out_rp_reg[OUT_AW]) &&
                      (out_wp_reg[OUT_AW-1:0] == out_rp_reg[OUT_AW-1:0]);
   assign out_head  = out_mem[out_rp_reg[OUT_AW-1:0]];

   assign out_push  = wr_active & i_io_ctr_last_cycle;
   assign dout_vld  = run_reg & ~out_empty;
   assign dout_xfer = dout_vld & i_core_dout_acp;
   assign out_pop   = dout_xfer & (out_idx_reg == CTR_LAST);

   for (genvar gi = 0; gi < NIBS; gi++) begin : g_out_nib
      assign out_word[gi*NIB_W +: NIB_W] =
         (i_io_ctr == CTR_W'(gi)) ? i_io_wr_data : wbuf_reg[gi];
      assign out_head_nib[gi] = out_head[gi*NIB_W +: NIB_W];
   end

   always_ff @(posedge i_core_gck) begin
      if (wr_active) wbuf_reg[i_io_ctr] <= i_io_wr_data;
      if (out_push)  out_mem[out_wp_reg[OUT_AW-1:0]] <= out_word;
   end

   always_ff @(posedge i_core_gck or negedge i_core_rst_n) begin
      if (!i_core_rst_n) begin
         out_idx_reg <= '0;
         out_wp_reg  <= '0;
         out_rp_reg  <= '0;
      end else begin
         if (dout_xfer) out_idx_reg <= out_idx_reg + CTR_ONE;
         if (out_push)  out_wp_reg  <= out_wp_reg + OUT_ONE;
         if (out_pop)   out_rp_reg  <= out_rp_reg + OUT_ONE;
      end
   end

   // ---------------- outputs ----------------
   assign o_core_din_acp  = din_acp;
   assign o_core_dout_vld = dout_vld;
   assign o_core_dout     = dout_vld ? out_head_nib[out_idx_reg] : '0;
   assign o_io_rd_vld     = rd_active;
   assign o_io_rd_data    = rd_active ? in_head_nib[i_io_ctr] : '0;
   assign o_io_stall      = rd_stall | wr_stall;

endmodule

// File: tb/tb_idli_io_unit_m.sv
// Directed bench for idli_io_unit_m: the bench drives the nibble counter and
// checks both handshake sides against hand-computed nibble sequences.
module tb_idli_io_unit_m;

   logic       clk;
   logic       rst_n;
   logic [1:0] ctr;
   logic       last;
   logic       rd_req;
   logic [3:0] rd_data;
   logic       rd_vld;
   logic       wr_req;
   logic [3:0] wr_data;
   logic       stall;
   logic [3:0] din;
   logic       din_vld;
   logic       din_acp;
   logic [3:0] dout;
   logic       dout_vld;
   logic       dout_acp;

   int checks = 0;
   int errors = 0;

   idli_io_unit_m dut (
      .i_core_gck          (clk),
      .i_core_rst_n        (rst_n),
      .i_io_ctr            (ctr),
      .i_io_ctr_last_cycle (last),
      .i_io_rd_req         (rd_req),
      .o_io_rd_data        (rd_data),
      .o_io_rd_vld         (rd_vld),
      .i_io_wr_req         (wr_req),
      .i_io_wr_data        (wr_data),
      .o_io_stall          (stall),
      .i_core_din          (din),
      .i_core_din_vld      (din_vld),
      .o_core_din_acp      (din_acp),
      .o_core_dout         (dout),
      .o_core_dout_vld     (dout_vld),
      .i_core_dout_acp     (dout_acp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      ctr  = ctr + 2'd1;
      last = (ctr == 2'd3);
   endtask

   task automatic align();
      while (ctr != 2'd0) tick();
   endtask

   task automatic send_word(input logic [15:0] w);
      for (int k = 0; k < 4; k++) begin
         din     = w[4*k +: 4];
         din_vld = 1'b1;
         tick();
      end
      din_vld = 1'b0;
      din     = 4'h0;
   endtask

   task automatic do_read(input logic [15:0] exp, input logic exp_stall, input string name);
      logic [5:0] exp_v;
      for (int k = 0; k < 4; k++) begin
         rd_req = (k == 0);
         #1;
         exp_v = exp_stall ? 6'b01_0000 : {2'b10, exp[4*k +: 4]};
         checks++;
         if ({rd_vld, stall, rd_data} !== exp_v) begin
            errors++;
            $display("FAIL %s k=%0d got vld=%b stall=%b data=%h want vld=%b stall=%b data=%h",
                     name, k, rd_vld, stall, rd_data, exp_v[5], exp_v[4], exp_v[3:0]);
         end
         tick();
      end
      rd_req = 1'b0;
   endtask

   task automatic write_word(input logic [15:0] w, input logic exp_stall, input string name);
      for (int k = 0; k < 4; k++) begin
         wr_req  = (k == 0);
         wr_data = w[4*k +: 4];
         #1;
         checks++;
         if (stall !== exp_stall) begin
            errors++;
            $display("FAIL %s k=%0d got stall=%b want %b", name, k, stall, exp_stall);
         end
         tick();
      end
      wr_req  = 1'b0;
      wr_data = 4'h0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({din_acp, dout_vld, rd_vld, stall, dout, rd_data} !== 12'h000) begin
         errors++;
         $display("FAIL reset_outputs got acp=%b dvld=%b rvld=%b stall=%b dout=%h rdata=%h want all 0",
                  din_acp, dout_vld, rd_vld, stall, dout, rd_data);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (din_acp !== 1'b0) begin
         errors++;
         $display("FAIL release_sync got acp=%b want 0", din_acp);
      end
      tick();
      #1;
      checks++;
      if ({din_acp, dout_vld, rd_vld, stall} !== 4'b1000) begin
         errors++;
         $display("FAIL idle got acp=%b dvld=%b rvld=%b stall=%b want 1 0 0 0",
                  din_acp, dout_vld, rd_vld, stall);
      end
   endtask

   task automatic test_basic_in();
      send_word(16'h1234);
      align();
      do_read(16'h1234, 1'b0, "basic_rd");
      do_read(16'h0000, 1'b1, "basic_empty_stall");
   endtask

   task automatic test_stall_empty();
      do_read(16'h0000, 1'b1, "empty_stall");
      send_word(16'hBEEF);
      align();
      do_read(16'hBEEF, 1'b0, "beef_rd");
   endtask

   task automatic test_fill();
      send_word(16'hA001);
      send_word(16'hA002);
      send_word(16'hA003);
      send_word(16'hA004);
      #1;
      checks++;
      if (din_acp !== 1'b0) begin
         errors++;
         $display("FAIL fill_acp_low got acp=%b want 0", din_acp);
      end
      din     = 4'h7;
      din_vld = 1'b1;
      tick();
      #1;
      checks++;
      if (din_acp !== 1'b0) begin
         errors++;
         $display("FAIL fill_hold got acp=%b want 0", din_acp);
      end
      align();
      do_read(16'hA001, 1'b0, "fill_pop");
      #1;
      checks++;
      if (din_acp !== 1'b1) begin
         errors++;
         $display("FAIL fill_acp_back got acp=%b want 1", din_acp);
      end
      tick();
      din = 4'h8; tick();
      din = 4'h9; tick();
      din = 4'hA; tick();
      din_vld = 1'b0;
      din     = 4'h0;
      align();
      do_read(16'hA002, 1'b0, "fill_rd2");
      do_read(16'hA003, 1'b0, "fill_rd3");
      do_read(16'hA004, 1'b0, "fill_rd4");
      do_read(16'hA987, 1'b0, "fill_rd_held");
      do_read(16'h0000, 1'b1, "fill_empty");
   endtask

   task automatic test_in_simul();
      logic [15:0] head_w;
      logic [15:0] tail_w;
      head_w = 16'hC001;
      tail_w = 16'hC004;
      send_word(16'hC001);
      send_word(16'hC002);
      send_word(16'hC003);
      align();
      for (int k = 0; k < 4; k++) begin
         rd_req  = (k == 0);
         din_vld = 1'b1;
         din     = tail_w[4*k +: 4];
         #1;
         checks++;
         if ({din_acp, rd_vld, stall, rd_data} !== {3'b110, head_w[4*k +: 4]}) begin
            errors++;
            $display("FAIL simul_in k=%0d got acp=%b vld=%b stall=%b data=%h want 1 1 0 %h",
                     k, din_acp, rd_vld, stall, rd_data, head_w[4*k +: 4]);
         end
         tick();
      end
      rd_req  = 1'b0;
      din_vld = 1'b0;
      din     = 4'h0;
      #1;
      checks++;
      if (din_acp !== 1'b1) begin
         errors++;
         $display("FAIL simul_in_count got acp=%b want 1", din_acp);
      end
      send_word(16'hC005);
      #1;
      checks++;
      if (din_acp !== 1'b0) begin
         errors++;
         $display("FAIL simul_in_full got acp=%b want 0", din_acp);
      end
      align();
      do_read(16'hC002, 1'b0, "simul_rd2");
      do_read(16'hC003, 1'b0, "simul_rd3");
      do_read(16'hC004, 1'b0, "simul_rd4");
      do_read(16'hC005, 1'b0, "simul_rd5");
   endtask

   task automatic test_out_basic();
      logic [15:0] w;
      w = 16'hC0A5;
      dout_acp = 1'b1;
      align();
      write_word(w, 1'b0, "out_basic_wr");
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++;
         if ({dout_vld, dout} !== {1'b1, w[4*k +: 4]}) begin
            errors++;
            $display("FAIL out_basic k=%0d got vld=%b dout=%h want 1 %h",
                     k, dout_vld, dout, w[4*k +: 4]);
         end
         tick();
      end
      #1;
      checks++;
      if ({dout_vld, dout} !== 5'h00) begin
         errors++;
         $display("FAIL out_drained got vld=%b dout=%h want 0 0", dout_vld, dout);
      end
   endtask

   task automatic test_out_full_simul();
      logic [15:0] w1;
      logic [15:0] w2;
      logic [47:0] rest;
      w1   = 16'h4321;
      w2   = 16'h8765;
      rest = {16'h9B3E, 16'h0FED, 16'hCBA9};
      dout_acp = 1'b0;
      align();
      write_word(16'h4321, 1'b0, "out_fill1");
      write_word(16'h8765, 1'b0, "out_fill2");
      write_word(16'hCBA9, 1'b0, "out_fill3");
      write_word(16'h0FED, 1'b0, "out_fill4");
      write_word(16'h5555, 1'b1, "out_full_stall");
      dout_acp = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++;
         if ({stall, dout_vld, dout} !== {2'b01, w1[4*k +: 4]}) begin
            errors++;
            $display("FAIL out_head k=%0d got stall=%b vld=%b dout=%h want 0 1 %h",
                     k, stall, dout_vld, dout, w1[4*k +: 4]);
         end
         tick();
      end
      for (int k = 0; k < 4; k++) begin
         wr_req  = (k == 0);
         wr_data = rest[32 + 4*k +: 4];
         #1;
         checks++;
         if ({stall, dout_vld, dout} !== {2'b01, w2[4*k +: 4]}) begin
            errors++;
            $display("FAIL out_simul k=%0d got stall=%b vld=%b dout=%h want 0 1 %h",
                     k, stall, dout_vld, dout, w2[4*k +: 4]);
         end
         tick();
      end
      wr_req  = 1'b0;
      wr_data = 4'h0;
      for (int j = 0; j < 12; j++) begin
         #1;
         checks++;
         if ({dout_vld, dout} !== {1'b1, rest[4*j +: 4]}) begin
            errors++;
            $display("FAIL out_drain j=%0d got vld=%b dout=%h want 1 %h",
                     j, dout_vld, dout, rest[4*j +: 4]);
         end
         tick();
      end
      #1;
      checks++;
      if (dout_vld !== 1'b0) begin
         errors++;
         $display("FAIL out_drain_end got vld=%b want 0", dout_vld);
      end
   endtask

   task automatic test_reset_mid();
      dout_acp = 1'b0;
      align();
      write_word(16'h7654, 1'b0, "mid_prefill");
      for (int k = 0; k < 2; k++) begin
         wr_req   = (k == 0);
         wr_data  = 4'(k + 1);
         din_vld  = 1'b1;
         din      = 4'h9;
         dout_acp = 1'b1;
         tick();
      end
      wr_req   = 1'b0;
      wr_data  = 4'h3;
      din_vld  = 1'b0;
      din      = 4'h0;
      dout_acp = 1'b0;
      #1;
      checks++;
      if ({dout_vld, dout} !== 5'h16) begin
         errors++;
         $display("FAIL mid_pre_idx got vld=%b dout=%h want 1 6", dout_vld, dout);
      end
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({din_acp, dout_vld, rd_vld, stall, dout, rd_data} !== 12'h000) begin
         errors++;
         $display("FAIL mid_reset_outs got acp=%b dvld=%b rvld=%b stall=%b dout=%h rdata=%h want all 0",
                  din_acp, dout_vld, rd_vld, stall, dout, rd_data);
      end
      wr_data = 4'h0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      #1;
      checks++;
      if ({din_acp, dout_vld, rd_vld, stall} !== 4'b1000) begin
         errors++;
         $display("FAIL mid_after got acp=%b dvld=%b rvld=%b stall=%b want 1 0 0 0",
                  din_acp, dout_vld, rd_vld, stall);
      end
      send_word(16'h4321);
      align();
      do_read(16'h4321, 1'b0, "mid_fresh");
      #1;
      checks++;
      if (dout_vld !== 1'b0) begin
         errors++;
         $display("FAIL mid_no_stale_out got vld=%b want 0", dout_vld);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      ctr      = 2'd0;
      last     = 1'b0;
      rd_req   = 1'b0;
      wr_req   = 1'b0;
      wr_data  = 4'h0;
      din      = 4'h0;
      din_vld  = 1'b0;
      dout_acp = 1'b0;
      test_reset();
      test_basic_in();
      test_stall_empty();
      test_fill();
      test_in_simul();
      test_out_basic();
      test_out_full_simul();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
